// File: rtl/shift_delay_line.sv
// Parameterised shift-register delay line with per-stage valid bits, a
// selectable combinational tap and a registered occupancy count.
module shift_delay_line #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int SW    = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         data_in,
   input  logic [SW-1:0]            tap_sel,
   output logic [WIDTH-1:0]         tap_data,
   output logic                     tap_valid,
   output logic [WIDTH*DEPTH-1:0]   stage_bus,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   output logic [$clog2(DEPTH+1)-1:0] fill_count,
   output logic                     full,
   output logic                     empty
);

   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [CW-1:0]    count_q, count_d;

   // in_valid only qualifies the word; there is no backpressure, so every
   // enabled edge shifts regardless of in_valid. Flush beats shift.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         data_d[k] = data_q[k];
      end
      valid_d = valid_q;
      count_d = count_q;
      if (flush) begin
         valid_d = '0;
         count_d = '0;
      end else if (en) begin
         data_d[0] = data_in;
         for (int k = 1; k < DEPTH; k++) begin
            data_d[k] = data_q[k-1];
         end
         valid_d = {valid_q[DEPTH-2:0], in_valid};
         count_d = count_q + CW'(in_valid) - CW'(valid_q[DEPTH-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            data_q[k] <= '0;
         end
         valid_q <= '0;
         count_q <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            data_q[k] <= data_d[k];
         end
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   // Out-of-range selects match no stage and leave the tap at zero.
   always_comb begin
      tap_data  = '0;
      tap_valid = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (tap_sel == SW'(k)) begin
            tap_data  = data_q[k];
            tap_valid = valid_q[k];
         end
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_bus
      assign stage_bus[g*WIDTH +: WIDTH] = data_q[g];
   end

   assign out_data   = data_q[DEPTH-1];
   assign out_valid  = valid_q[DEPTH-1];
   assign fill_count = count_q;
   assign full       = (count_q == CW'(DEPTH));
   assign empty      = (count_q == '0);

endmodule

// File: doc/shift_delay_line.md
SHIFT_DELAY_LINE -- requirements
Module: shift_delay_line

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the data width per stage in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of stages (DEPTH >= 2).
REQ-003 The block SHALL have parameter SW, default $clog2(DEPTH), meaning the tap-select width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: shift enable; when low, all stages hold.
REQ-007 The block SHALL have port flush, input, 1 bit: clears all stage valid bits.
REQ-008 The block SHALL have port in_valid, input, 1 bit: qualifies data_in.
REQ-009 The block SHALL have port data_in, input, WIDTH bits: word entering stage 0.
REQ-010 The block SHALL have port tap_sel, input, SW bits: selects the stage index driven on tap_data.
REQ-011 The block SHALL have port tap_data, output, WIDTH bits: data of the selected stage.
REQ-012 The block SHALL have port tap_valid, output, 1 bit: valid bit of the selected stage.
REQ-013 The block SHALL have port stage_bus, output, WIDTH*DEPTH bits: all stages flattened, stage k at bits [k*WIDTH +: WIDTH].
REQ-014 The block SHALL have port out_data, output, WIDTH bits: last stage (DEPTH-1).
REQ-015 The block SHALL have port out_valid, output, 1 bit: valid bit of the last stage.
REQ-016 The block SHALL have port fill_count, output, $clog2(DEPTH+1) bits: number of valid stages.
REQ-017 The block SHALL have port full, output, 1 bit: high when fill_count == DEPTH.
REQ-018 The block SHALL have port empty, output, 1 bit: high when fill_count == 0.

Function
REQ-019 The block SHALL hold a registered data word and valid bit per stage, plus a registered fill_count.
REQ-020 Shift rule: with en=1 and flush=0, on the edge stage 0 SHALL load data_in/in_valid and stage k SHALL load stage k-1 (k=1..DEPTH-1); stage DEPTH-1 content is discarded.
REQ-021 Hold rule: with en=0 and flush=0, all data, valid bits and fill_count SHALL hold.
REQ-022 Latency: a word accepted on enabled edge n SHALL be in stage k after enabled edge n+k and SHALL appear on out_data after DEPTH enabled edges total; stall cycles add no shifting.
REQ-023 Invalid words (in_valid=0) SHALL shift like valid ones, data included; only the valid bit differs.
REQ-024 Flush: flush=1 SHALL clear all valid bits and fill_count to 0 on the edge; data registers SHALL hold.
REQ-025 Simultaneous flush and en: flush SHALL win; no shift occurs and the in_valid word is dropped.
REQ-026 fill_count SHALL equal the popcount of the stage valid bits after every edge (on shift: +in_valid, -last-stage valid; saturation never needed).
REQ-027 full and empty SHALL be combinational decodes of fill_count.
REQ-028 tap_data/tap_valid SHALL be combinational from stage tap_sel; if tap_sel >= DEPTH, both SHALL be 0.
REQ-029 out_data, out_valid and stage_bus SHALL be direct register outputs (no combinational path from inputs).

Reset
REQ-030 reset=1 on an edge SHALL force all data words to 0, all valid bits to 0 and fill_count to 0, regardless of en, flush or in_valid.
REQ-031 Reset SHALL take priority over flush and en; reset asserted mid-fill SHALL discard all contents on that edge.
REQ-032 Post-reset outputs SHALL be: out_data=0, out_valid=0, stage_bus=0, full=0, empty=1; tap_data=0 and tap_valid=0 for any tap_sel.

Verification (WIDTH=16, DEPTH=8 unless stated)
REQ-033 Reset for 2 edges with en=1, in_valid=1, data_in=0xABCD -> stage_bus=0, fill_count=0, empty=1, out_valid=0.
REQ-034 en=1, in_valid=1, data_in=0x0001..0x0008 on 8 edges -> out_data=0x0001, out_valid=1, stage k holds 0x0008-k, fill_count=8, full=1.
REQ-035 Fill 4 words, en=0 for 3 edges, then 4 more -> stage_bus unchanged during the stall; the final state matches REQ-034.
REQ-036 8 shifts with in_valid alternating 1,0 starting at 1 -> fill_count=4, valid bits set on stages 1,3,5,7; then flush with en=1 -> fill_count=0, empty=1, data unchanged, no shift.
REQ-037 Full line from REQ-034 with tap_sel=3 -> tap_data=0x0005, tap_valid=1; DEPTH=6 build with tap_sel=7 -> tap_data=0, tap_valid=0.
REQ-038 Reset asserted at fill_count=5 with en=1 and flush=1 -> next edge all zero; a following 3-shift fill gives fill_count=3.
